hazard_ctrl_unit: RTL and testbench

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

---
 rtl/hazard_ctrl_if.sv | 52 +++++
 rtl/hazard_ctrl_unit.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_if : pipeline-state inputs and stall/flush controls of the
//                  hazard control unit. Revision: 1.0
// ============================================================================
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int OPC_W = 8,
    parameter int CNT_W = 16
);
    logic             if_id_valid;
    logic [OPC_W-1:0] if_id_opcode;
    logic [REG_W-1:0] if_id_rs1;
    logic [REG_W-1:0] if_id_rs2;
    logic             id_ex_memread;
    logic             id_ex_regwrite;
    logic [REG_W-1:0] id_ex_rd;
    logic             ex_mem_memread;
    logic             ex_mem_regwrite;
    logic [REG_W-1:0] ex_mem_rd;
    logic             br_taken;
    logic             mc_start;
    logic             mc_done;
    logic             cnt_clr;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_hold;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: supplies stage state, consumes the controls.
    modport master (
        output if_id_valid, if_id_opcode, if_id_rs1, if_id_rs2,
        output id_ex_memread, id_ex_regwrite, id_ex_rd,
        output ex_mem_memread, ex_mem_regwrite, ex_mem_rd,
        output br_taken, mc_start, mc_done, cnt_clr,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  if_id_valid, if_id_opcode, if_id_rs1, if_id_rs2,
        input  id_ex_memread, id_ex_regwrite, id_ex_rd,
        input  ex_mem_memread, ex_mem_regwrite, ex_mem_rd,
        input  br_taken, mc_start, mc_done, cnt_clr,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
        output stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_unit : stall/flush/bubble control for a 5-stage pipeline with
//                    ID-stage branches and multi-cycle EX ops. Revision: 1.0
// ============================================================================
module hazard_ctrl_unit #(
    parameter int REG_W  = 5,
    parameter int OPC_W  = 8,
    parameter int CNT_W  = 16,
    parameter int BR_FWD = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic       w_branch, w_jal, w_jalr;
    logic [2:0] w_funct3;
    logic [4:0] w_op5;
    logic       w_dep_idex, w_dep_exmem;
    logic       w_exmem_nofwd_haz;
    logic       w_mc_stall, w_load_use, w_br_data, w_redirect;

    function automatic logic dep_match(
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs1,
        input logic [REG_W-1:0] rs2,
        input logic             valid
    );
        return valid && (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

    assign w_funct3 = hz.if_id_opcode[7:5];
    assign w_op5    = hz.if_id_opcode[4:0];
    assign w_branch = (w_op5 == 5'b11000) && (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
    assign w_jal    = (w_op5 == 5'b11011);
    assign w_jalr   = (hz.if_id_opcode[7:0] == 8'b000_11001);

    assign w_dep_idex  = dep_match(hz.id_ex_rd,  hz.if_id_rs1, hz.if_id_rs2, hz.if_id_valid);
    assign w_dep_exmem = dep_match(hz.ex_mem_rd, hz.if_id_rs1, hz.if_id_rs2, hz.if_id_valid);

    // Without EX/MEM forwarding into ID, any EX/MEM writer feeding a compare must drain first.
    generate
        if (BR_FWD != 0) begin : g_br_fwd
            assign w_exmem_nofwd_haz = 1'b0;
        end else begin : g_br_nofwd
            assign w_exmem_nofwd_haz = hz.ex_mem_regwrite && w_dep_exmem;
        end
    endgenerate

    assign w_mc_stall = ((r_state == RUN) && hz.mc_start && !hz.mc_done) ||
                        ((r_state == MC_BUSY) && !hz.mc_done);
    assign w_load_use = hz.id_ex_memread && w_dep_idex;
    assign w_br_data  = (w_branch || w_jalr) &&
                        ((hz.id_ex_regwrite && w_dep_idex) ||
                         (hz.ex_mem_memread && w_dep_exmem) ||
                         w_exmem_nofwd_haz);
    assign w_redirect = w_jal || w_jalr || (w_branch && hz.br_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_bubble = 1'b0;
        hz.ex_hold      = 1'b0;

        case (r_state)
            RUN:     if (hz.mc_start && !hz.mc_done) w_state_nxt = MC_BUSY;
            MC_BUSY: if (hz.mc_done)                 w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase

        if (w_mc_stall) begin
            hz.pc_write    = 1'b0;
            hz.if_id_write = 1'b0;
            hz.ex_hold     = 1'b1;
        end else if (w_load_use || w_br_data) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.id_ex_bubble = 1'b1;
        end else if (w_redirect) begin
            hz.if_id_flush = 1'b1;
        end

        // Held in reset, the pipeline is frozen and fed bubbles.
        if (!rst_n) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.if_id_flush  = 1'b1;
            hz.id_ex_bubble = 1'b1;
            hz.ex_hold      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (hz.cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!hz.pc_write && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (hz.if_id_flush && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl_unit : directed bench for hazard_ctrl_unit (default, no-forward
//                       and 4-bit counter variants). Revision: 1.0
// ============================================================================
module tb_hazard_ctrl_unit;
    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold}
    localparam logic [4:0] C_NORM  = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_MC    = 5'b00001;
    localparam logic [4:0] C_REDIR = 5'b11100;
    localparam logic [4:0] C_RST   = 5'b00110;
    localparam logic [7:0] OP_ALU  = 8'b000_01100;
    localparam logic [7:0] OP_BEQ  = 8'b000_11000;
    localparam logic [7:0] OP_BNE  = 8'b001_11000;
    localparam logic [7:0] OP_B010 = 8'b010_11000;
    localparam logic [7:0] OP_JAL  = 8'b000_11011;
    localparam logic [7:0] OP_JALR = 8'b000_11001;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(5), .OPC_W(8), .CNT_W(16)) hz ();
    hazard_ctrl_if #(.REG_W(5), .OPC_W(8), .CNT_W(16)) hz_nf ();
    hazard_ctrl_if #(.REG_W(5), .OPC_W(8), .CNT_W(4))  hz_c4 ();

    hazard_ctrl_unit #(.REG_W(5), .OPC_W(8), .CNT_W(16), .BR_FWD(1)) u_dut (.clk(clk), .rst_n(rst_n), .hz(hz));
    hazard_ctrl_unit #(.REG_W(5), .OPC_W(8), .CNT_W(16), .BR_FWD(0)) u_nf  (.clk(clk), .rst_n(rst_n), .hz(hz_nf));
    hazard_ctrl_unit #(.REG_W(5), .OPC_W(8), .CNT_W(4),  .BR_FWD(1)) u_c4  (.clk(clk), .rst_n(rst_n), .hz(hz_c4));

    assign hz_nf.if_id_valid = hz.if_id_valid;   assign hz_c4.if_id_valid = hz.if_id_valid;
    assign hz_nf.if_id_opcode = hz.if_id_opcode; assign hz_c4.if_id_opcode = hz.if_id_opcode;
    assign hz_nf.if_id_rs1 = hz.if_id_rs1;       assign hz_c4.if_id_rs1 = hz.if_id_rs1;
    assign hz_nf.if_id_rs2 = hz.if_id_rs2;       assign hz_c4.if_id_rs2 = hz.if_id_rs2;
    assign hz_nf.id_ex_memread = hz.id_ex_memread;     assign hz_c4.id_ex_memread = hz.id_ex_memread;
    assign hz_nf.id_ex_regwrite = hz.id_ex_regwrite;   assign hz_c4.id_ex_regwrite = hz.id_ex_regwrite;
    assign hz_nf.id_ex_rd = hz.id_ex_rd;               assign hz_c4.id_ex_rd = hz.id_ex_rd;
    assign hz_nf.ex_mem_memread = hz.ex_mem_memread;   assign hz_c4.ex_mem_memread = hz.ex_mem_memread;
    assign hz_nf.ex_mem_regwrite = hz.ex_mem_regwrite; assign hz_c4.ex_mem_regwrite = hz.ex_mem_regwrite;
    assign hz_nf.ex_mem_rd = hz.ex_mem_rd;             assign hz_c4.ex_mem_rd = hz.ex_mem_rd;
    assign hz_nf.br_taken = hz.br_taken;   assign hz_c4.br_taken = hz.br_taken;
    assign hz_nf.mc_start = hz.mc_start;   assign hz_c4.mc_start = hz.mc_start;
    assign hz_nf.mc_done = hz.mc_done;     assign hz_c4.mc_done = hz.mc_done;
    assign hz_nf.cnt_clr = hz.cnt_clr;     assign hz_c4.cnt_clr = hz.cnt_clr;

    wire [4:0] ctl    = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_bubble, hz.ex_hold};
    wire [4:0] ctl_nf = {hz_nf.pc_write, hz_nf.if_id_write, hz_nf.if_id_flush, hz_nf.id_ex_bubble, hz_nf.ex_hold};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.if_id_valid = 1'b0; hz.if_id_opcode = OP_ALU;
        hz.if_id_rs1 = '0; hz.if_id_rs2 = '0;
        hz.id_ex_memread = 1'b0; hz.id_ex_regwrite = 1'b0; hz.id_ex_rd = '0;
        hz.ex_mem_memread = 1'b0; hz.ex_mem_regwrite = 1'b0; hz.ex_mem_rd = '0;
        hz.br_taken = 1'b0; hz.mc_start = 1'b0; hz.mc_done = 1'b0; hz.cnt_clr = 1'b0;
    endtask

    task automatic clear_cnt();
        idle();
        hz.cnt_clr = 1'b1;
        step();
        hz.cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #3;
        total++; if (ctl !== C_RST) begin bad++; $display("FAIL rst_ctl act=%b exp=%b", ctl, C_RST); end
        step();
        step();
        #2 rst_n = 1'b1;
        #1;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL rst_rel_ctl act=%b exp=%b", ctl, C_NORM); end
        step();
        total++; if (hz.stall_cnt !== 16'd0 || hz.flush_cnt !== 16'd0) begin
            bad++; $display("FAIL rst_cnt act=%0d/%0d exp=0/0", hz.stall_cnt, hz.flush_cnt);
        end
    endtask

    task automatic test_load_use();
        clear_cnt();
        hz.if_id_valid = 1'b1; hz.if_id_opcode = OP_ALU; hz.if_id_rs1 = 5'd1; hz.if_id_rs2 = 5'd5;
        hz.id_ex_memread = 1'b1; hz.id_ex_rd = 5'd5;
        #2;
        total++; if (ctl !== C_STALL) begin bad++; $display("FAIL lu_ctl act=%b exp=%b", ctl, C_STALL); end
        step();
        total++; if (hz.stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt act=%0d exp=1", hz.stall_cnt); end
        hz.id_ex_rd = 5'd0; hz.if_id_rs2 = 5'd0;
        #2;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL lu_x0 act=%b exp=%b", ctl, C_NORM); end
        hz.id_ex_rd = 5'd5; hz.if_id_rs2 = 5'd5; hz.if_id_valid = 1'b0;
        #2;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL lu_invalid act=%b exp=%b", ctl, C_NORM); end
        step();
        total++; if (hz.stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt_hold act=%0d exp=1", hz.stall_cnt); end
    endtask

    task automatic test_branch_data();
        idle();
        hz.if_id_valid = 1'b1; hz.if_id_opcode = OP_BEQ; hz.if_id_rs1 = 5'd3; hz.if_id_rs2 = 5'd4;
        hz.ex_mem_regwrite = 1'b1; hz.ex_mem_rd = 5'd3;
        #2;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL br_fwd act=%b exp=%b", ctl, C_NORM); end
        total++; if (ctl_nf !== C_STALL) begin bad++; $display("FAIL br_nofwd act=%b exp=%b", ctl_nf, C_STALL); end
        hz.ex_mem_regwrite = 1'b0; hz.ex_mem_memread = 1'b1;
        #2;
        total++; if (ctl !== C_STALL) begin bad++; $display("FAIL br_exmem_load act=%b exp=%b", ctl, C_STALL); end
        hz.ex_mem_memread = 1'b0; hz.id_ex_regwrite = 1'b1; hz.id_ex_rd = 5'd4;
        #2;
        total++; if (ctl !== C_STALL) begin bad++; $display("FAIL br_idex_rs2 act=%b exp=%b", ctl, C_STALL); end
        hz.if_id_opcode = OP_B010;
        #2;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL br_f3_010 act=%b exp=%b", ctl, C_NORM); end
        hz.if_id_opcode = OP_JALR; hz.if_id_rs1 = 5'd4;
        #2;
        total++; if (ctl !== C_STALL) begin bad++; $display("FAIL jalr_data act=%b exp=%b", ctl, C_STALL); end
        step();
    endtask

    task automatic test_multicycle();
        clear_cnt();
        hz.mc_start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            total++; if (ctl !== C_MC) begin bad++; $display("FAIL mc_cyc%0d act=%b exp=%b", c, ctl, C_MC); end
            step();
            hz.mc_start = 1'b0;
        end
        hz.mc_done = 1'b1;
        #2;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL mc_done act=%b exp=%b", ctl, C_NORM); end
        step();
        hz.mc_done = 1'b0;
        total++; if (hz.stall_cnt !== 16'd4) begin bad++; $display("FAIL mc_cnt act=%0d exp=4", hz.stall_cnt); end
        hz.mc_start = 1'b1; hz.mc_done = 1'b1;
        #2;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL mc_same act=%b exp=%b", ctl, C_NORM); end
        step();
        idle();
        #2;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL mc_same_after act=%b exp=%b", ctl, C_NORM); end
        step();
    endtask

    task automatic test_priority();
        clear_cnt();
        hz.if_id_valid = 1'b1; hz.if_id_rs1 = 5'd7; hz.id_ex_memread = 1'b1; hz.id_ex_rd = 5'd7;
        hz.mc_start = 1'b1;
        #2;
        total++; if (ctl !== C_MC) begin bad++; $display("FAIL pri_mc_lu act=%b exp=%b", ctl, C_MC); end
        step();
        hz.mc_start = 1'b0;
        #2;
        total++; if (ctl !== C_MC) begin bad++; $display("FAIL pri_busy_lu act=%b exp=%b", ctl, C_MC); end
        step();
        hz.mc_done = 1'b1;
        #2;
        total++; if (ctl !== C_STALL) begin bad++; $display("FAIL pri_done_lu act=%b exp=%b", ctl, C_STALL); end
        step();
        clear_cnt();
        hz.if_id_valid = 1'b1; hz.if_id_opcode = OP_BNE; hz.if_id_rs1 = 5'd6; hz.if_id_rs2 = 5'd7;
        hz.br_taken = 1'b1;
        #2;
        total++; if (ctl !== C_REDIR) begin bad++; $display("FAIL redir_bne act=%b exp=%b", ctl, C_REDIR); end
        step();
        total++; if (hz.flush_cnt !== 16'd1) begin bad++; $display("FAIL redir_cnt act=%0d exp=1", hz.flush_cnt); end
        hz.if_id_opcode = OP_JAL; hz.br_taken = 1'b0;
        #2;
        total++; if (ctl !== C_REDIR) begin bad++; $display("FAIL redir_jal act=%b exp=%b", ctl, C_REDIR); end
        step();
        hz.if_id_opcode = OP_JALR;
        #2;
        total++; if (ctl !== C_REDIR) begin bad++; $display("FAIL redir_jalr act=%b exp=%b", ctl, C_REDIR); end
        step();
        hz.if_id_opcode = OP_BNE;
        #2;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL bne_untaken act=%b exp=%b", ctl, C_NORM); end
        step();
        hz.br_taken = 1'b1; hz.id_ex_memread = 1'b1; hz.id_ex_rd = 5'd6;
        #2;
        total++; if (ctl !== C_STALL) begin bad++; $display("FAIL lu_over_redir act=%b exp=%b", ctl, C_STALL); end
        step();
        total++; if (hz.flush_cnt !== 16'd3) begin bad++; $display("FAIL redir_cnt3 act=%0d exp=3", hz.flush_cnt); end
    endtask

    task automatic test_saturate();
        clear_cnt();
        hz.if_id_valid = 1'b1; hz.if_id_rs1 = 5'd9; hz.id_ex_memread = 1'b1; hz.id_ex_rd = 5'd9;
        for (int c = 0; c < 20; c++) step();
        total++; if (hz_c4.stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_c4 act=%0d exp=15", hz_c4.stall_cnt); end
        total++; if (hz.stall_cnt !== 16'd20) begin bad++; $display("FAIL sat_c16 act=%0d exp=20", hz.stall_cnt); end
        hz.cnt_clr = 1'b1;
        step();
        hz.cnt_clr = 1'b0;
        total++; if (hz_c4.stall_cnt !== 4'd0 || hz.stall_cnt !== 16'd0) begin
            bad++; $display("FAIL clr_prio act=%0d/%0d exp=0/0", hz_c4.stall_cnt, hz.stall_cnt);
        end
        step();
        total++; if (hz_c4.stall_cnt !== 4'd1) begin bad++; $display("FAIL clr_resume act=%0d exp=1", hz_c4.stall_cnt); end
    endtask

    task automatic test_reset_mid_mc();
        clear_cnt();
        hz.mc_start = 1'b1;
        step();
        hz.mc_start = 1'b0;
        step();
        total++; if (hz.stall_cnt !== 16'd2) begin bad++; $display("FAIL rmc_pre act=%0d exp=2", hz.stall_cnt); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (hz.stall_cnt !== 16'd0) begin bad++; $display("FAIL rmc_async_cnt act=%0d exp=0", hz.stall_cnt); end
        total++; if (ctl !== C_RST) begin bad++; $display("FAIL rmc_rst_ctl act=%b exp=%b", ctl, C_RST); end
        step();
        #2 rst_n = 1'b1;
        #1;
        total++; if (ctl !== C_NORM) begin bad++; $display("FAIL rmc_after act=%b exp=%b", ctl, C_NORM); end
        step();
        total++; if (hz.stall_cnt !== 16'd0) begin bad++; $display("FAIL rmc_cnt_after act=%0d exp=0", hz.stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_data();
        test_multicycle();
        test_priority();
        test_saturate();
        test_reset_mid_mc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
